// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-wide memory/IO arbiter.
// Holds the FSM state encoding, access-size codes and the IO address decode.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GR_NONE = 2'd0,
        GR_IF   = 2'd1,
        GR_LSB  = 2'd2
    } grant_e;

    localparam logic [1:0]  SZ_B    = 2'b00;
    localparam logic [1:0]  SZ_H    = 2'b01;
    localparam logic [1:0]  SZ_W    = 2'b10;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    // IO space is the whole 64 KiB window selected by addr[17:16].
    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and RAM/IO port signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        inst_ready;
    logic [31:0] inst;

    logic        lsb_req;
    logic        lsb_we;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  if_enable, if_addr, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
               mem_din, io_buffer_full,
        output inst_ready, inst, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_enable, if_addr, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
               mem_din, io_buffer_full,
        input  inst_ready, inst, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter owning the byte-wide RAM/IO port: round-robin between fetch and
// load/store, each grant run as a byte burst that assembles or serialises a word.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear,
    mem_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    grant_e      last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        inst_ready_q, inst_ready_d;
    logic [31:0] inst_q, inst_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        lsb_wins;
    logic        grant_lsb;
    logic        grant_if;
    logic [31:0] byte_addr;
    logic [31:0] rd_word;
    logic        last_byte;

    assign lsb_wins  = (last_q == GR_IF) || ((last_q == GR_NONE) && LSB_FIRST);
    assign grant_lsb = bus.lsb_req && (!bus.if_enable || lsb_wins);
    assign grant_if  = bus.if_enable && !grant_lsb;

    assign byte_addr = addr_q + {29'd0, cnt_q};
    // data_q is zeroed at grant, so OR-ing in the current byte is enough.
    assign rd_word   = data_q | ({24'd0, bus.mem_din} << {cnt_q[1:0], 3'b000});
    assign last_byte = (cnt_q == nbytes_q - 3'd1);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;
        inst_ready_d = 1'b0;
        inst_d       = inst_q;
        lsb_done_d   = 1'b0;
        lsb_rdata_d  = lsb_rdata_q;

        // A paused edge holds everything except the one-cycle strobes.
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    mem_a_d = '0;
                    if (!clear && (grant_if || grant_lsb)) begin
                        cnt_d  = 3'd0;
                        data_d = '0;
                        if (grant_if) begin
                            state_d  = ST_IF_RD;
                            last_d   = GR_IF;
                            addr_d   = bus.if_addr;
                            nbytes_d = 3'd4;
                            mem_a_d  = bus.if_addr;
                        end else begin
                            last_d   = GR_LSB;
                            addr_d   = bus.lsb_addr;
                            wdata_d  = bus.lsb_wdata;
                            nbytes_d = size_to_nbytes(bus.lsb_size);
                            mem_a_d  = bus.lsb_addr;
                            if (bus.lsb_we) begin
                                state_d = ST_LS_WR;
                                // Byte 0 goes out on the grant edge unless the IO sink is full.
                                if (!(is_io(bus.lsb_addr) && bus.io_buffer_full)) begin
                                    mem_wr_d   = 1'b1;
                                    mem_dout_d = bus.lsb_wdata[7:0];
                                    cnt_d      = 3'd1;
                                end
                            end else begin
                                state_d = ST_LS_RD;
                            end
                        end
                    end
                end

                ST_IF_RD, ST_LS_RD: begin
                    if (clear) begin
                        state_d = ST_IDLE;
                        mem_a_d = '0;
                    end else begin
                        data_d = rd_word;
                        if (last_byte) begin
                            state_d = ST_IDLE;
                            mem_a_d = '0;
                            if (state_q == ST_IF_RD) begin
                                inst_d       = rd_word;
                                inst_ready_d = 1'b1;
                            end else begin
                                lsb_rdata_d = rd_word;
                                lsb_done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d   = cnt_q + 3'd1;
                            mem_a_d = byte_addr + 32'd1;
                        end
                    end
                end

                ST_LS_WR: begin
                    // Stores ignore clear: once granted they always commit.
                    if (cnt_q == nbytes_q) begin
                        state_d    = ST_IDLE;
                        mem_a_d    = '0;
                        lsb_done_d = 1'b1;
                    end else begin
                        mem_a_d = byte_addr;
                        if (!(is_io(byte_addr) && bus.io_buffer_full)) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = byte_sel(wdata_q, cnt_q[1:0]);
                            cnt_d      = cnt_q + 3'd1;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            last_q       <= GR_NONE;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            inst_ready_q <= 1'b0;
            inst_q       <= '0;
            lsb_done_q   <= 1'b0;
            lsb_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            inst_ready_q <= inst_ready_d;
            inst_q       <= inst_d;
            lsb_done_q   <= lsb_done_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.inst       = inst_q;
    assign bus.lsb_done   = lsb_done_q;
    assign bus.lsb_rdata  = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte RAM model answers the port, expected
// fetch/load words and write bytes are queued at stimulus time and popped on output.
module tb_mem_arbiter;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic clear  = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter #(.LSB_FIRST(1'b1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int wr_cnt   = 0;
    int inst_cnt = 0;

    logic [31:0] q_inst [$];
    logic [31:0] q_ld   [$];
    logic [39:0] q_wr   [$];

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        if (a == 0) return 8'h13;
        if (a == 1 || a == 2) return 8'h00;
        if (a == 3) return 8'h93;
        return 8'((a * 7 + 5) & 255);
    endfunction

    function automatic logic [31:0] word_at(input int a);
        return {pat(a + 3), pat(a + 2), pat(a + 1), pat(a)};
    endfunction

    function automatic logic tb_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    // RAM model: the arbiter's registered mem_a is the one cycle of latency.
    logic [7:0] ram [0:4095];
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 4096; i++) ram[i[11:0]] <= pat(i);
        end else if (bus.mem_wr && !tb_io(bus.mem_a)) begin
            ram[bus.mem_a[11:0]] <= bus.mem_dout;
        end
    end
    assign bus.mem_din = ram[bus.mem_a[11:0]];

    // Output monitor / scoreboard.
    always @(posedge clk_in) begin
        #1;
        if (rst_in) begin
            if (bus.inst_ready) begin
                inst_cnt++;
                $display("[%0t] fetch inst=%h", $time, bus.inst);
                if (q_inst.size() == 0) chk("inst_unexpected", 40'd1, 40'd0);
                else chk("inst_word", 40'(bus.inst), 40'(q_inst.pop_front()));
            end
            if (bus.lsb_done) begin
                if (!bus.lsb_we) begin
                    $display("[%0t] load rdata=%h", $time, bus.lsb_rdata);
                    if (q_ld.size() == 0) chk("load_unexpected", 40'd1, 40'd0);
                    else chk("load_word", 40'(bus.lsb_rdata), 40'(q_ld.pop_front()));
                end else begin
                    $display("[%0t] store done", $time);
                end
            end
            if (bus.mem_wr) begin
                wr_cnt++;
                $display("[%0t] write a=%h d=%h", $time, bus.mem_a, bus.mem_dout);
                if (q_wr.size() == 0) chk("wr_unexpected", 40'd1, 40'd0);
                else chk("wr_byte", {bus.mem_a, bus.mem_dout}, q_wr.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input bit is_inst, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(is_inst ? bus.inst_ready : bus.lsb_done) && n < bound);
        if (!(is_inst ? bus.inst_ready : bus.lsb_done))
            chk(is_inst ? "timeout_inst" : "timeout_lsb", 40'd0, 40'd1);
    endtask

    task automatic lsb_drive(input logic we, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.lsb_req   = 1'b1;
        bus.lsb_we    = we;
        bus.lsb_size  = sz;
        bus.lsb_addr  = a;
        bus.lsb_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        int i0;
        bus.if_enable      = 1'b0;
        bus.if_addr        = '0;
        bus.lsb_req        = 1'b0;
        bus.lsb_we         = 1'b0;
        bus.lsb_size       = 2'b00;
        bus.lsb_addr       = '0;
        bus.lsb_wdata      = '0;
        bus.io_buffer_full = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_in);
        chk("rst_mem_a",      40'(bus.mem_a),      40'd0);
        chk("rst_mem_wr",     40'(bus.mem_wr),     40'd0);
        chk("rst_inst_ready", 40'(bus.inst_ready), 40'd0);
        chk("rst_lsb_done",   40'(bus.lsb_done),   40'd0);
        rst_in = 1'b1;

        // Fetch word at 0: address walk, 5-edge latency, one-cycle pulse
        @(negedge clk_in);
        bus.if_enable = 1'b1;
        bus.if_addr   = 32'h0;
        q_inst.push_back(32'h9300_0013);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fetch_mem_a", 40'(bus.mem_a), 40'(k));
            if (k == 0) begin
                @(negedge clk_in);
                bus.if_enable = 1'b0;
            end
        end
        step();
        chk("fetch_ready", 40'(bus.inst_ready), 40'd1);
        step();
        chk("fetch_pulse_len", 40'(bus.inst_ready), 40'd0);
        chk("fetch_inst_hold", 40'(bus.inst),       40'h9300_0013);
        chk("idle_mem_a",      40'(bus.mem_a),      40'd0);

        // Both pending from a fresh reset: LSB, fetch, LSB with one dead cycle each
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        lsb_drive(1'b0, 2'b10, 32'h100, 32'h0);
        bus.if_enable = 1'b1;
        bus.if_addr   = 32'h4;
        q_ld.push_back(word_at(32'h100));
        q_inst.push_back(word_at(4));
        wait_done(1'b0, 12, n);
        chk("rr_lsb_first", 40'(n), 40'd5);
        @(negedge clk_in);
        bus.lsb_addr = 32'h104;
        q_ld.push_back(word_at(32'h104));
        wait_done(1'b1, 12, n);
        chk("rr_fetch_second", 40'(n), 40'd5);
        @(negedge clk_in);
        bus.if_enable = 1'b0;
        wait_done(1'b0, 12, n);
        chk("rr_lsb_third", 40'(n), 40'd5);
        @(negedge clk_in);
        bus.lsb_req = 1'b0;

        // Half-word store
        @(negedge clk_in);
        w0 = wr_cnt;
        lsb_drive(1'b1, 2'b01, 32'h200, 32'hAABB_CCDD);
        q_wr.push_back({32'h200, 8'hDD});
        q_wr.push_back({32'h201, 8'hCC});
        wait_done(1'b0, 10, n);
        chk("sth_latency",   40'(n),              40'd3);
        chk("sth_wr_cycles", 40'(wr_cnt - w0),    40'd2);
        chk("sth_ram_200",   40'(ram[12'h200]),   40'hDD);
        chk("sth_ram_202",   40'(ram[12'h202]),   40'(pat(32'h202)));
        @(negedge clk_in);
        bus.lsb_req = 1'b0;

        // clear at cnt=2 of a fetch aborts it
        @(negedge clk_in);
        i0 = inst_cnt;
        bus.if_enable = 1'b1;
        bus.if_addr   = 32'h8;
        step();
        step();
        step();
        chk("clr_pre_mem_a", 40'(bus.mem_a), 40'hA);
        @(negedge clk_in);
        clear = 1'b1;
        bus.if_enable = 1'b0;
        step();
        chk("clr_rd_mem_a", 40'(bus.mem_a), 40'd0);
        @(negedge clk_in);
        clear = 1'b0;
        repeat (6) step();
        chk("clr_no_inst", 40'(inst_cnt - i0), 40'd0);

        // clear during a word store does not stop it
        @(negedge clk_in);
        lsb_drive(1'b1, 2'b10, 32'h300, 32'h1122_3344);
        q_wr.push_back({32'h300, 8'h44});
        q_wr.push_back({32'h301, 8'h33});
        q_wr.push_back({32'h302, 8'h22});
        q_wr.push_back({32'h303, 8'h11});
        step();
        @(negedge clk_in);
        clear = 1'b1;
        step();
        @(negedge clk_in);
        clear = 1'b0;
        wait_done(1'b0, 10, n);
        chk("clr_st_latency", 40'(n),             40'd3);
        chk("clr_st_all_wr",  40'(q_wr.size()),   40'd0);
        @(negedge clk_in);
        bus.lsb_req = 1'b0;

        // IO byte store held off by io_buffer_full for 3 edges
        @(negedge clk_in);
        bus.io_buffer_full = 1'b1;
        lsb_drive(1'b1, 2'b00, 32'h0003_0000, 32'h0000_005A);
        q_wr.push_back({32'h0003_0000, 8'h5A});
        for (int k = 0; k < 3; k++) begin
            step();
            chk("io_stall_wr", 40'(bus.mem_wr), 40'd0);
        end
        @(negedge clk_in);
        bus.io_buffer_full = 1'b0;
        step();
        chk("io_wr",      40'(bus.mem_wr), 40'd1);
        chk("io_wr_addr", 40'(bus.mem_a),  40'h0003_0000);
        step();
        chk("io_done", 40'(bus.lsb_done), 40'd1);
        @(negedge clk_in);
        bus.lsb_req = 1'b0;

        // Pause mid-load
        @(negedge clk_in);
        lsb_drive(1'b0, 2'b10, 32'h180, 32'h0);
        q_ld.push_back(word_at(32'h180));
        step();
        step();
        @(negedge clk_in);
        rdy_in = 1'b0;
        step();
        chk("pause_mem_a", 40'(bus.mem_a),  40'h181);
        chk("pause_wr",    40'(bus.mem_wr), 40'd0);
        step();
        chk("pause_mem_a2", 40'(bus.mem_a), 40'h181);
        @(negedge clk_in);
        rdy_in = 1'b1;
        wait_done(1'b0, 10, n);
        chk("pause_resume", 40'(n), 40'd3);

        // Async reset in the middle of a burst
        @(negedge clk_in);
        bus.lsb_addr = 32'h1C0;
        step();
        step();
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_mem_a",     40'(bus.mem_a),      40'd0);
        chk("arst_lsb_rdata", 40'(bus.lsb_rdata),  40'd0);
        chk("arst_inst",      40'(bus.inst),       40'd0);
        chk("arst_lsb_done",  40'(bus.lsb_done),   40'd0);
        chk("arst_mem_wr",    40'(bus.mem_wr),     40'd0);
        bus.lsb_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", 40'(bus.mem_a), 40'd0);
        chk("q_empty", 40'(q_inst.size() + q_ld.size() + q_wr.size()), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
